// File: rtl/dram_if_pkg.sv
// dram_if_pkg: shared DRAM bus defaults and burst-reader state encoding.
package dram_if_pkg;
    localparam int ADDR_WIDTH = 25;
    localparam int DATA_WIDTH = 256;
    localparam int BCNT_WIDTH = 5;
    localparam int BURST_LEN  = 16;
    typedef enum logic [2:0] {IDLE, SPACE, CMD, DATA, FIN} rd_state_e;
endpackage

// File: rtl/dram_burst_reader_if.sv
// dram_burst_reader_if: control, Avalon-MM read and output stream signals of the burst reader.
// master: the reader (drives busy/done, Avalon command, stream data); slave: its environment.
interface dram_burst_reader_if #(
    parameter int ADDR_WIDTH = dram_if_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = dram_if_pkg::DATA_WIDTH,
    parameter int BCNT_WIDTH = dram_if_pkg::BCNT_WIDTH,
    parameter int NB_WIDTH   = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_address;
    logic [NB_WIDTH-1:0]   num_bursts;
    logic                  busy;
    logic                  done;
    logic                  DRAM_Wait_Request;
    logic [ADDR_WIDTH-1:0] DRAM_RD_address;
    logic                  DRAM_Read;
    logic [BCNT_WIDTH-1:0] DRAM_Read_Burst_Count;
    logic                  DRAM_Read_Burst_Begin;
    logic                  DRAM_Read_Data_Valid;
    logic [DATA_WIDTH-1:0] DRAM_Read_Data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    modport master (
        input  start, start_address, num_bursts, DRAM_Wait_Request,
               DRAM_Read_Data_Valid, DRAM_Read_Data, out_ready,
        output busy, done, DRAM_RD_address, DRAM_Read, DRAM_Read_Burst_Count,
               DRAM_Read_Burst_Begin, out_data, out_valid
    );
    modport slave (
        output start, start_address, num_bursts, DRAM_Wait_Request,
               DRAM_Read_Data_Valid, DRAM_Read_Data, out_ready,
        input  busy, done, DRAM_RD_address, DRAM_Read, DRAM_Read_Burst_Count,
               DRAM_Read_Burst_Begin, out_data, out_valid
    );
endinterface

// File: rtl/dram_rd_fifo.sv
// dram_rd_fifo: first-word-fall-through FIFO holding returned DRAM words.
// Ports: clk_i, rst_ni (async, active low), push_i/din_i write, pop_i read,
// dout_o head word (0 when empty), empty_o, full_o, used_o occupancy.
module dram_rd_fifo #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        din_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        dout_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   used_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int UW = $clog2(DEPTH + 1);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [UW-1:0] used_q;
    assign empty_o = used_q == '0;
    assign full_o  = used_q == UW'(DEPTH);
    assign used_o  = used_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            used_q <= '0;
        end else begin
            wr_q   <= push_i ? wr_q + PW'(1) : wr_q;
            rd_q   <= pop_i ? rd_q + PW'(1) : rd_q;
            used_q <= used_q + UW'(push_i) - UW'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push_i && full_o && !pop_i)) else $error("dram_rd_fifo overflow");
            assert (!(pop_i && empty_o)) else $error("dram_rd_fifo underflow");
        end
    end
endmodule

// File: rtl/dram_burst_reader.sv
// dram_burst_reader: Avalon-MM burst read master streaming a DRAM region through a FIFO.
// Ports: avalon_clk, rst_n (async, active low), bus (master modport): start/start_address/
// num_bursts request with busy/done status, Avalon read command and readdata return,
// out_data/out_valid/out_ready first-word-fall-through output stream.
module dram_burst_reader #(
    parameter int ADDR_WIDTH = dram_if_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = dram_if_pkg::DATA_WIDTH,
    parameter int BURST_LEN  = dram_if_pkg::BURST_LEN,
    parameter int BCNT_WIDTH = dram_if_pkg::BCNT_WIDTH,
    parameter int FIFO_DEPTH = 32,
    parameter int NB_WIDTH   = 16
) (
    input  logic                        avalon_clk,
    input  logic                        rst_n,
    dram_burst_reader_if.master         bus
);
    import dram_if_pkg::*;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int UW     = $clog2(FIFO_DEPTH + 1);
    rd_state_e             state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NB_WIDTH-1:0]   rem_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  busy_q, done_q, read_q, begin_q;
    logic                  push, pop, empty, full, last_beat, space_ok, last_burst;
    logic [UW-1:0]         used;
    // Readdatavalid outside DATA (e.g. a burst cut short by reset) is dropped.
    assign push       = state_q == DATA && bus.DRAM_Read_Data_Valid;
    assign pop        = !empty && bus.out_ready;
    assign last_beat  = push && beat_q == BEAT_W'(BURST_LEN - 1);
    assign last_burst = rem_q == NB_WIDTH'(1);
    // Only one burst is ever outstanding and SPACE is entered after it has fully
    // returned, so the free-slot count here needs no in-flight correction.
    assign space_ok   = !full && used <= UW'(FIFO_DEPTH - BURST_LEN);
    always_ff @(posedge avalon_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            read_q  <= 1'b0;
            begin_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    addr_q  <= bus.start_address;
                    rem_q   <= bus.num_bursts;
                    done_q  <= bus.num_bursts == '0;
                    busy_q  <= bus.num_bursts != '0;
                    state_q <= bus.num_bursts == '0 ? IDLE : SPACE;
                end
                SPACE: if (space_ok) begin
                    read_q  <= 1'b1;
                    begin_q <= 1'b1;
                    state_q <= CMD;
                end
                CMD: begin
                    begin_q <= 1'b0;
                    if (!bus.DRAM_Wait_Request) begin
                        read_q  <= 1'b0;
                        beat_q  <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: if (push) begin
                    beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        addr_q  <= addr_q + ADDR_WIDTH'(BURST_LEN);
                        rem_q   <= rem_q - NB_WIDTH'(1);
                        done_q  <= last_burst;
                        busy_q  <= !last_burst;
                        state_q <= last_burst ? FIN : SPACE;
                    end
                end
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    dram_rd_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (avalon_clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .din_i   (bus.DRAM_Read_Data),
        .pop_i   (pop),
        .dout_o  (bus.out_data),
        .empty_o (empty),
        .full_o  (full),
        .used_o  (used)
    );
    assign bus.busy                  = busy_q;
    assign bus.done                  = done_q;
    assign bus.DRAM_RD_address       = addr_q;
    assign bus.DRAM_Read             = read_q;
    assign bus.DRAM_Read_Burst_Count = read_q ? BCNT_WIDTH'(BURST_LEN) : '0;
    assign bus.DRAM_Read_Burst_Begin = begin_q;
    assign bus.out_valid             = !empty;
endmodule

// File: tb/tb_dram_burst_reader.sv
// tb_dram_burst_reader: table-driven and directed checks of dram_burst_reader against a DRAM model.
module tb_dram_burst_reader;
    import dram_if_pkg::*;
    typedef struct {
        string                 name;
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           nb;
        int                    wait_cyc;
        int                    exp_cmds;
        logic [ADDR_WIDTH-1:0] exp_cmd1;
        int                    exp_words;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    dram_burst_reader_if bus ();
    dram_burst_reader dut (.avalon_clk(clk), .rst_n(rst_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    logic [ADDR_WIDTH-1:0] cmd_q[$];
    logic [ADDR_WIDTH-1:0] rx_q[$];
    int mdl_beats = 0;
    bit mdl_busy = 1'b0;
    int proto_err = 0, read_cycles = 0, done_cnt = 0, done_beats = 0;
    logic prev_read = 1'b0, prev_wait = 1'b0;
    logic [ADDR_WIDTH-1:0] prev_addr = '0;
    vec_t vecs[5];

    // DRAM model: accepts a command seen at a negedge, returns word = address + i
    // starting one cycle after acceptance, with a one-cycle bubble before beat 5.
    initial begin
        logic [ADDR_WIDTH-1:0] a;
        bus.DRAM_Read_Data_Valid = 1'b0;
        bus.DRAM_Read_Data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.DRAM_Read && !bus.DRAM_Wait_Request) begin
                a = bus.DRAM_RD_address;
                cmd_q.push_back(a);
                mdl_busy = 1'b1;
                @(posedge clk); #1;
                for (int i = 0; i < BURST_LEN; i++) begin
                    if (i == 5) begin
                        bus.DRAM_Read_Data_Valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    bus.DRAM_Read_Data_Valid = 1'b1;
                    bus.DRAM_Read_Data = DATA_WIDTH'(a + ADDR_WIDTH'(i));
                    @(posedge clk);
                    mdl_beats++;
                    #1;
                end
                bus.DRAM_Read_Data_Valid = 1'b0;
                mdl_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            proto_err <= proto_err
                + int'(bus.DRAM_Read && bus.DRAM_Read_Burst_Count != BCNT_WIDTH'(BURST_LEN))
                + int'(bus.DRAM_Read_Burst_Begin != (bus.DRAM_Read && !prev_read))
                + int'(prev_read && prev_wait && (!bus.DRAM_Read || bus.DRAM_RD_address != prev_addr));
            if (bus.DRAM_Read) read_cycles <= read_cycles + 1;
            if (bus.done) begin
                done_cnt <= done_cnt + 1;
                done_beats <= mdl_beats;
            end
            if (bus.out_valid && bus.out_ready) rx_q.push_back(bus.out_data[ADDR_WIDTH-1:0]);
        end
        prev_read <= rst_n && bus.DRAM_Read;
        prev_wait <= bus.DRAM_Wait_Request;
        prev_addr <= bus.DRAM_RD_address;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int order_errs(input int base, input logic [ADDR_WIDTH-1:0] a, input int n);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (base + k >= rx_q.size() || rx_q[base + k] !== a + ADDR_WIDTH'(k)) e++;
        return e;
    endfunction

    task automatic pulse_start(input logic [ADDR_WIDTH-1:0] a, input logic [15:0] n);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.start_address = a;
        bus.num_bursts = n;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int db);
        int to = 0;
        while (done_cnt == db && to < 3000) begin
            @(negedge clk);
            to++;
        end
        check({name, "_done_timeout"}, 64'(to >= 3000), 64'(0));
        to = 0;
        while ((bus.out_valid || mdl_busy) && to < 300) begin
            @(negedge clk);
            to++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_case(input vec_t v);
        int cb = cmd_q.size(), rb = rx_q.size(), db = done_cnt, pb = proto_err;
        int rcb = read_cycles, bb = mdl_beats, to = 0;
        bus.out_ready = 1'b1;
        bus.DRAM_Wait_Request = v.wait_cyc > 0;
        pulse_start(v.addr, v.nb);
        @(negedge clk);
        check({v.name, "_busy"}, 64'(bus.busy), 64'(v.nb != 0));
        check({v.name, "_done_next"}, 64'(bus.done), 64'(v.nb == 0));
        if (v.wait_cyc > 0) begin
            while (!bus.DRAM_Read && to < 100) begin
                @(negedge clk);
                to++;
            end
            check({v.name, "_cmd_timeout"}, 64'(to >= 100), 64'(0));
            repeat (v.wait_cyc - 1) @(negedge clk);
            @(posedge clk); #1;
            bus.DRAM_Wait_Request = 1'b0;
        end
        wait_done(v.name, db);
        check({v.name, "_cmds"}, 64'(cmd_q.size() - cb), 64'(v.exp_cmds));
        if (v.exp_cmds > 0) check({v.name, "_cmd0"}, 64'(cmd_q[cb]), 64'(v.addr));
        if (v.exp_cmds > 1) check({v.name, "_cmd1"}, 64'(cmd_q[cb + 1]), 64'(v.exp_cmd1));
        check({v.name, "_words"}, 64'(rx_q.size() - rb), 64'(v.exp_words));
        check({v.name, "_order"}, 64'(order_errs(rb, v.addr, v.exp_words)), 64'(0));
        check({v.name, "_done_cnt"}, 64'(done_cnt - db), 64'(1));
        check({v.name, "_beats_at_done"}, 64'(done_beats - bb), 64'(v.exp_words));
        check({v.name, "_read_cycles"}, 64'(read_cycles - rcb), 64'(v.exp_cmds + v.wait_cyc));
        check({v.name, "_protocol"}, 64'(proto_err - pb), 64'(0));
        check({v.name, "_idle_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int cb, rb, db, bb, to;
        vecs[0] = '{"basic", 25'h0000100, 16'd2, 0, 2, 25'h0000110, 32};
        vecs[1] = '{"waitreq", 25'h0000200, 16'd1, 5, 1, 25'h0000000, 16};
        vecs[2] = '{"wrap", 25'h1FFFFF0, 16'd2, 0, 2, 25'h0000000, 32};
        vecs[3] = '{"zero", 25'h0000400, 16'd0, 0, 0, 25'h0000000, 0};
        vecs[4] = '{"triple", 25'h0ABC000, 16'd3, 0, 3, 25'h0ABC010, 48};
        bus.start = 1'b0;
        bus.start_address = '0;
        bus.num_bursts = '0;
        bus.DRAM_Wait_Request = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_read", 64'(bus.DRAM_Read), 64'(0));
        check("rst_cmd", 64'({bus.DRAM_RD_address, bus.DRAM_Read_Burst_Count, bus.DRAM_Read_Burst_Begin}), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_case(vecs[i]);

        // Start while busy must be ignored.
        cb = cmd_q.size(); rb = rx_q.size(); db = done_cnt;
        bus.out_ready = 1'b1;
        pulse_start(25'h0000300, 16'd1);
        repeat (2) @(posedge clk);
        pulse_start(25'h0005000, 16'd5);
        wait_done("ignored", db);
        repeat (100) @(negedge clk);
        check("ignored_cmds", 64'(cmd_q.size() - cb), 64'(1));
        check("ignored_cmd0", 64'(cmd_q[cb]), 64'(25'h0000300));
        check("ignored_words", 64'(rx_q.size() - rb), 64'(16));
        check("ignored_done_cnt", 64'(done_cnt - db), 64'(1));

        // Backpressure: FIFO of 32 holds only two bursts until 16 words drain.
        cb = cmd_q.size(); rb = rx_q.size(); db = done_cnt;
        bus.out_ready = 1'b0;
        pulse_start(25'h0004000, 16'd4);
        repeat (80) @(negedge clk);
        check("bp_two_bursts", 64'(cmd_q.size() - cb), 64'(2));
        check("bp_no_pop", 64'(rx_q.size() - rb), 64'(0));
        check("bp_out_valid", 64'(bus.out_valid), 64'(1));
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (80) @(negedge clk);
        check("bp_third_burst", 64'(cmd_q.size() - cb), 64'(3));
        check("bp_16_popped", 64'(rx_q.size() - rb), 64'(16));
        bus.out_ready = 1'b1;
        wait_done("bp", db);
        check("bp_cmds", 64'(cmd_q.size() - cb), 64'(4));
        check("bp_words", 64'(rx_q.size() - rb), 64'(64));
        check("bp_order", 64'(order_errs(rb, 25'h0004000, 64)), 64'(0));

        // Reset after 7 beats of the first burst; trailing beats must be dropped.
        bb = mdl_beats;
        bus.out_ready = 1'b0;
        pulse_start(25'h0000600, 16'd2);
        to = 0;
        while (mdl_beats - bb < 7 && to < 200) begin
            @(negedge clk);
            to++;
        end
        check("rst_mid_timeout", 64'(to >= 200), 64'(0));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(bus.busy), 64'(0));
        check("rst_mid_cmd", 64'({bus.DRAM_RD_address, bus.DRAM_Read, bus.DRAM_Read_Burst_Count, bus.DRAM_Read_Burst_Begin}), 64'(0));
        check("rst_mid_out", 64'({bus.out_valid, bus.done, bus.out_data[ADDR_WIDTH-1:0]}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        to = 0;
        while (mdl_busy && to < 100) begin
            @(negedge clk);
            to++;
        end
        repeat (3) @(negedge clk);
        check("rst_mid_fifo_empty", 64'(bus.out_valid), 64'(0));
        check("rst_mid_idle_busy", 64'(bus.busy), 64'(0));
        run_case(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
